alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, sequential successor to the combinational `alu`: accepts one operation per valid/ready handshake, registers the result and status flags, and holds them until the consumer takes them. Single-cycle ops return in 1 cycle; an optional iterative shift-add multiplier takes WIDTH cycles. It sits between the decode/operand-fetch stage and writeback in the multi-cycle processor datapath, and the handshake provides the backpressure.

## Interface
- WIDTH, 16: operand/result width; power of two, 4..64.
- localparam SHW = $clog2(WIDTH): width of the shift amount.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept.
- op  in  5  opcode.
- x  in  WIDTH  operand X.
- y  in  WIDTH  operand Y.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes result.
- z  out  WIDTH  result.
- zero  out  1  z == 0.
- neg  out  1  z[WIDTH-1].
- carry  out  1  ADD carry-out; SUB borrow (x < y unsigned); 0 for all other ops.
- illegal  out  1  op unsupported; z = 0.

## Operation
- Opcodes:
  - 0 ADD; 1 SUB (x-y); 2 AND; 3 OR; 4 XOR; 5 NOT x.
  - 6 SHL, 7 SHR logical, 8 SRA: x shifted by y[SHW-1:0].
  - 9 SLT: signed compare, z = {0…, x<y}.
  - 10 MUL: low WIDTH bits of x*y.
  - 11–31: illegal.
- Accept: rising edge with in_valid && in_ready. x, y and op are captured at that edge.
- States:
  - IDLE: in_ready=1.
  - BUSY: MUL in progress; in_ready=0.
  - DONE: out_valid=1.
- Transitions:
  - IDLE→DONE on accept of a non-MUL op.
  - IDLE→BUSY on accept of MUL.
  - BUSY→DONE after WIDTH iterations.
  - DONE→IDLE on out_ready when no new accept.
  - DONE→DONE on out_ready with a simultaneous accept of a non-MUL op (back-to-back).
  - DONE→BUSY on out_ready with a simultaneous accept of MUL.
- in_ready = IDLE || (DONE && out_ready). It is combinational from state and out_ready, and is 0 while reset is high.
- Multiplier:
  - Captures multiplicand, multiplier and a counter.
  - Each BUSY cycle: if the multiplier LSB is 1, add the multiplicand to the accumulator. Then shift the multiplicand left and the multiplier right.
  - The counter is $clog2(WIDTH)+1 bits wide, so it counts WIDTH without wrap.
- z and flags change only on entry to DONE. They are stable while out_valid && !out_ready.
- Flags are computed from the final z. carry is from the (WIDTH+1)-bit sum/difference.

## Timing
- Reset values: out_valid=0, z=0, zero=0, neg=0, carry=0, illegal=0, state IDLE. in_ready=1 in the first cycle after reset deasserts.
- Latency from accept edge to out_valid=1:
  - Non-MUL: 1 edge.
  - MUL: WIDTH+1 edges (1 to BUSY, then WIDTH in BUSY).
- Throughput: 1 non-MUL op per cycle when out_ready is held high.
- Reset mid-MUL or in DONE: aborts; the result is discarded, with no partial output.
- in_valid during BUSY: ignored (in_ready=0). The source must hold the op.
- Illegal op: 1-cycle latency, z=0, illegal=1, zero=1, carry=0.

## Configuration
- ALU_SEQ_MUL_EN defined: MUL is implemented as above.
- ALU_SEQ_MUL_EN undefined:
  - The BUSY state and multiplier registers are not compiled.
  - Op 10 behaves as illegal (1-cycle, z=0, illegal=1).

## Test plan
- WIDTH=16, ADD x=16'hFFFF, y=16'h0001, out_ready=1 → next cycle out_valid=1, z=0, zero=1, carry=1, neg=0.
- SUB x=3, y=5 → z=16'hFFFE, neg=1, carry=1. SRA x=16'h8000, y=16'h0013 (amount 3) → z=16'hF000.
- Back-to-back: AND, OR, XOR on consecutive cycles with out_ready=1 → three results on consecutive cycles, in_ready stays 1. Then hold out_ready=0 → z is stable and in_ready=0 until release.
- MUL x=123, y=45 with ALU_SEQ_MUL_EN → in_ready=0 for 16 cycles, out_valid on edge 17, z=5535. Same op without the macro → z=0, illegal=1 after 1 cycle.
- Reset asserted at BUSY cycle 8 of MUL → the next cycle has out_valid=0, z=0, in_ready=1; no stale result ever appears.
- Opcode 31 → illegal=1, z=0, zero=1. SLT x=16'hFFFF (−1), y=0 → z=1.

Source files
------------

// File: rtl/alu_seq_if.sv
// Operation/result handshake bundle for alu_seq: request side (in_*, op, x, y) and
// held result side (out_*, z, flags).
interface alu_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       op;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z;
  logic             zero;
  logic             neg;
  logic             carry;
  logic             illegal;

  modport master (
    output in_valid, op, x, y, out_ready,
    input  in_ready, out_valid, z, zero, neg, carry, illegal
  );

  modport slave (
    input  in_valid, op, x, y, out_ready,
    output in_ready, out_valid, z, zero, neg, carry, illegal
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: one op per valid/ready accept, result and flags held until taken.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier (op 10).
module alu_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus
);
  localparam int unsigned SHW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [1:0]       w_accept_state;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_is_mul;
  logic             w_load_alu;
  logic             w_mul_last;
  logic [WIDTH-1:0] w_mul_z;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_alu_z;
  logic             w_alu_carry;
  logic             w_alu_ill;
  logic [WIDTH-1:0] w_new_z;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_z;
  logic             r_zero;
  logic             r_neg;
  logic             r_carry;
  logic             r_illegal;

  assign w_in_ready = !reset && ((r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready));
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_load_alu = w_accept && !w_is_mul;

`ifdef ALU_SEQ_MUL_EN
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [4:0] OP_MUL = 5'd10;

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [SHW:0]     r_cnt;

  assign w_is_mul       = (bus.op == OP_MUL);
  assign w_accept_state = w_is_mul ? S_BUSY : S_DONE;
  assign w_mul_z        = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_last     = (r_state == S_BUSY) && (r_cnt == (SHW+1)'(1));

  // Counter runs down from WIDTH; the step taken at count 1 is the last one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_accept && w_is_mul) begin
      r_mcand  <= bus.x;
      r_mplier <= bus.y;
      r_acc    <= '0;
      r_cnt    <= (SHW+1)'(WIDTH);
    end else if (r_state == S_BUSY) begin
      r_acc    <= w_mul_z;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - (SHW+1)'(1);
    end
  end
`else
  assign w_is_mul       = 1'b0;
  assign w_accept_state = S_DONE;
  assign w_mul_z        = '0;
  assign w_mul_last     = 1'b0;
`endif

  assign w_sum   = {1'b0, bus.x} + {1'b0, bus.y};
  assign w_diff  = {1'b0, bus.x} - {1'b0, bus.y};
  assign w_shamt = bus.y[SHW-1:0];

  // Single-cycle datapath; anything not decoded is illegal with z = 0.
  always_comb begin
    w_alu_z     = '0;
    w_alu_carry = 1'b0;
    w_alu_ill   = 1'b0;
    case (bus.op)
      5'd0: begin
        w_alu_z     = w_sum[WIDTH-1:0];
        w_alu_carry = w_sum[WIDTH];
      end
      5'd1: begin
        w_alu_z     = w_diff[WIDTH-1:0];
        w_alu_carry = w_diff[WIDTH];
      end
      5'd2: w_alu_z = bus.x & bus.y;
      5'd3: w_alu_z = bus.x | bus.y;
      5'd4: w_alu_z = bus.x ^ bus.y;
      5'd5: w_alu_z = ~bus.x;
      5'd6: w_alu_z = bus.x << w_shamt;
      5'd7: w_alu_z = bus.x >> w_shamt;
      5'd8: w_alu_z = $signed(bus.x) >>> w_shamt;
      5'd9: w_alu_z = WIDTH'($signed(bus.x) < $signed(bus.y));
`ifdef ALU_SEQ_MUL_EN
      5'd10: w_alu_ill = 1'b0;
`endif
      default: w_alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_accept_state;
`ifdef ALU_SEQ_MUL_EN
      S_BUSY: if (w_mul_last) w_state_nxt = S_DONE;
`endif
      S_DONE: begin
        if (w_accept)           w_state_nxt = w_accept_state;
        else if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  assign w_new_z = w_load_alu ? w_alu_z : w_mul_z;

  // Result and flags move only when a result enters DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_z         <= '0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_carry     <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_out_valid <= (w_state_nxt == S_DONE);
      if (w_load_alu || w_mul_last) begin
        r_z       <= w_new_z;
        r_zero    <= (w_new_z == '0);
        r_neg     <= w_new_z[WIDTH-1];
        r_carry   <= w_load_alu && w_alu_carry;
        r_illegal <= w_load_alu && w_alu_ill;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.z         = r_z;
  assign bus.zero      = r_zero;
  assign bus.neg       = r_neg;
  assign bus.carry     = r_carry;
  assign bus.illegal   = r_illegal;
endmodule

// File: tb/tb_alu_seq.sv
// Randomised bench for alu_seq against an arithmetic reference model; honours ALU_SEQ_MUL_EN.
module tb_alu_seq;
  localparam int unsigned W = 16;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Reference: results from plain integer arithmetic on the operand values.
  task automatic ref_alu(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] z, output logic c, output logic ill);
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    int              sh = int'(ub % 64'(W));
    z = '0; c = 1'b0; ill = 1'b0;
    case (op)
      5'd0: begin z = W'(ua + ub); c = (ua + ub) >= (64'd1 << W); end
      5'd1: begin z = W'(ua - ub); c = ua < ub; end
      5'd2: z = a & b;
      5'd3: z = a | b;
      5'd4: z = a ^ b;
      5'd5: z = ~a;
      5'd6: z = W'(ua << sh);
      5'd7: z = W'(ua >> sh);
      5'd8: z = W'(sa >>> sh);
      5'd9: z = (sa < sb) ? W'(1) : W'(0);
      5'd10: if (MUL_EN) z = W'(ua * ub); else ill = 1'b1;
      default: ill = 1'b1;
    endcase
  endtask

  // One transaction from IDLE; result held for 'hold' cycles before it is taken.
  task automatic do_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    logic [W-1:0] ez, zs;
    logic         ec, eil;
    int           lat, exp_lat;
    bit           busy_ok;
    ref_alu(op, a, b, ez, ec, eil);
    exp_lat = (op == 5'd10 && MUL_EN) ? W + 1 : 1;
    bus.op = op; bus.x = a; bus.y = b; bus.in_valid = 1'b1;
    bus.out_ready = (hold == 0);
    #1;
    chk("in_ready_idle", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.x = W'($urandom); bus.y = W'($urandom); bus.op = 5'($urandom);
    lat = 1; busy_ok = 1'b1;
    while (!bus.out_valid && lat < int'(W) + 8) begin
      if (bus.in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("busy_in_ready_low", 64'(busy_ok), 64'd1);
    chk("z", 64'(bus.z), 64'(ez));
    chk("zero", 64'(bus.zero), 64'(ez == '0));
    chk("neg", 64'(bus.neg), 64'(ez[W-1]));
    chk("carry", 64'(bus.carry), 64'(ec));
    chk("illegal", 64'(bus.illegal), 64'(eil));
    zs = bus.z;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_z", 64'(bus.z), 64'(zs));
      chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("consumed", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] ez [3];
    logic         ec, eil;
    logic [W-1:0] zs;
    bit           no_stale;
    logic [4:0]   rop;

    bus.in_valid = 1'b0; bus.op = '0; bus.x = '0; bus.y = '0; bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("in_ready_in_reset", 64'(bus.in_ready), 64'd0);
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_z", 64'(bus.z), 64'd0);
    chk("rst_flags", 64'({bus.zero, bus.neg, bus.carry, bus.illegal}), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Directed points from the test plan
    do_op(5'd0,  16'hFFFF, 16'h0001, 0);
    do_op(5'd1,  16'h0003, 16'h0005, 1);
    do_op(5'd8,  16'h8000, 16'h0013, 0);
    do_op(5'd31, 16'h1234, 16'h5678, 0);
    do_op(5'd9,  16'hFFFF, 16'h0000, 0);
    do_op(5'd10, 16'd123,  16'd45,   2);
    do_op(5'd6,  16'h0001, 16'h000F, 0);
    do_op(5'd5,  16'hFFFF, 16'h0000, 0);

    // Back-to-back AND, OR, XOR with out_ready held high, then backpressure
    ref_alu(5'd2, 16'hF0F0, 16'h3C3C, ez[0], ec, eil);
    ref_alu(5'd3, 16'h0F00, 16'h00F0, ez[1], ec, eil);
    ref_alu(5'd4, 16'hAAAA, 16'hFFFF, ez[2], ec, eil);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.op = 5'd2; bus.x = 16'hF0F0; bus.y = 16'h3C3C;
    @(posedge clk); #1;
    chk("b2b0_valid", 64'(bus.out_valid), 64'd1);
    chk("b2b0_z", 64'(bus.z), 64'(ez[0]));
    chk("b2b0_in_ready", 64'(bus.in_ready), 64'd1);
    bus.op = 5'd3; bus.x = 16'h0F00; bus.y = 16'h00F0;
    @(posedge clk); #1;
    chk("b2b1_valid", 64'(bus.out_valid), 64'd1);
    chk("b2b1_z", 64'(bus.z), 64'(ez[1]));
    chk("b2b1_in_ready", 64'(bus.in_ready), 64'd1);
    bus.op = 5'd4; bus.x = 16'hAAAA; bus.y = 16'hFFFF;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    #1;
    chk("b2b2_valid", 64'(bus.out_valid), 64'd1);
    chk("b2b2_z", 64'(bus.z), 64'(ez[2]));
    chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
    zs = bus.z;
    repeat (3) begin
      @(posedge clk); #1;
      chk("stall_z", 64'(bus.z), 64'(zs));
      chk("stall_valid", 64'(bus.out_valid), 64'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b0;

    // Reset while MUL is busy (or while its illegal result waits in DONE)
    bus.in_valid = 1'b1; bus.op = 5'd10; bus.x = 16'd123; bus.y = 16'd45;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("abort_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_z", 64'(bus.z), 64'd0);
    chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
    no_stale = 1'b1;
    bus.out_ready = 1'b1;
    repeat (2 * W) begin
      @(posedge clk); #1;
      if (bus.out_valid) no_stale = 1'b0;
    end
    chk("abort_no_stale", 64'(no_stale), 64'd1);
    bus.out_ready = 1'b0;

    // Random operations with random backpressure
    for (int n = 0; n < 40; n++) begin
      rop = 5'($urandom_range(0, 12));
      if (rop > 5'd10) rop = 5'($urandom_range(11, 31));
      do_op(rop, W'($urandom), W'($urandom), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
